store_align_buffer: RTL and testbench
=====================================

STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

Interface
REQ-001 Parameter BYTE_WIDTH, default 8, bits per byte lane; data width is 4*BYTE_WIDTH.
REQ-002 Parameter DEPTH, default 2, number of buffered store entries; legal values are powers of two, 2 or greater.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 st_valid  in  1  store request valid from execute stage.
REQ-006 st_ready  out  1  buffer can accept a request this cycle.
REQ-007 st_addr  in  32  byte address of store.
REQ-008 st_data  in  4*BYTE_WIDTH  store data, right-justified (byte in lane 0, half in lanes 1:0).
REQ-009 st_mask  in  4  size mask: 0001 byte, 0011 half, 1111 word, 0000 no-op.
REQ-010 mem_wr_valid  out  1  write request to data memory valid.
REQ-011 mem_wr_ready  in  1  data memory accepts write.
REQ-012 mem_wr_addr  out  32  word address, bits [1:0] always 0.
REQ-013 mem_wr_data  out  4*BYTE_WIDTH  lane-aligned write data.
REQ-014 mem_wr_be  out  4  per-lane byte enable.
REQ-015 misaligned  out  1  one-cycle pulse flagging a rejected misaligned store.
REQ-016 empty  out  1  no entries buffered.

Function
REQ-017 Accept when st_valid && st_ready on a rising edge; offset = st_addr[1:0].
REQ-018 Byte enable = st_mask shifted left by offset; data = st_data shifted left by offset*BYTE_WIDTH, with vacated lanes zero.
REQ-019 Misaligned: any st_mask bit shifted beyond lane 3 (half at offset 3; word at offset 1, 2 or 3); the request is consumed, not enqueued, and misaligned = 1 the following cycle.
REQ-020 st_mask 0000: consumed, not enqueued, no misaligned pulse.
REQ-021 Illegal masks (any other value) are treated as misaligned.
REQ-022 Entry stores {st_addr[31:2],2'b00, aligned data, byte enable}; FIFO order, circular read/write pointers wrapping at DEPTH, count of width log2(DEPTH)+1.
REQ-023 st_ready = (count < DEPTH); registered-state only, no combinational path from mem_wr_ready.
REQ-024 mem_wr_valid = (count != 0); mem_wr_addr/data/be driven from head entry.
REQ-025 Once mem_wr_valid is high, head outputs hold stable until mem_wr_valid && mem_wr_ready.
REQ-026 Latency: request accepted at edge N appears on mem_wr_* in cycle after edge N (earliest handshake at edge N+1) when buffer was empty.
REQ-027 Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
REQ-028 Simultaneous rejected request (misaligned or no-op) and dequeue: count decrements only.
REQ-029 Full (count = DEPTH): st_ready = 0 that cycle even if mem_wr_ready = 1.
REQ-030 empty = (count == 0).

Reset
REQ-031 On rst high at an edge: pointers, count = 0; mem_wr_valid = 0; misaligned = 0; empty = 1; st_ready = 1 the next cycle.
REQ-032 Reset mid-operation discards all buffered entries without issuing writes; a write presented in the reset cycle is not considered accepted.
REQ-033 Entry storage contents need not be reset; mem_wr_addr/data/be are don't-care while mem_wr_valid = 0.

Structure
REQ-034 Shared package holds mask constants (byte/half/word/none) and default BYTE_WIDTH.
REQ-035 One combinational sub-module store_aligner computes byte enable, shifted data and the misaligned flag; FIFO and handshake logic stay in store_align_buffer.

Verification
REQ-036 Byte store addr 0x1003, data 0x000000AB, mask 0001 -> mem_wr_addr 0x1000, be 1000, data 0xAB000000, next cycle.
REQ-037 Half store addr 0x2002, data 0x0000BEEF, mask 0011 -> addr 0x2000, be 1100, data 0xBEEF0000; half at 0x2003 -> misaligned pulse, no write.
REQ-038 mem_wr_ready = 0, three word stores back-to-back -> first two accepted, st_ready = 0 on third until a dequeue; order preserved.
REQ-039 Full buffer, mem_wr_ready = 1 with st_valid held -> one dequeue and one enqueue per cycle after st_ready re-rises, count stays at or below 2, no loss.
REQ-040 Two entries queued, rst pulsed -> mem_wr_valid = 0, empty = 1 next cycle; no stale writes afterward.
REQ-041 Mask 0000 at addr 0x3001 -> accepted, no write, no misaligned pulse.

Source files
------------

// File: rtl/store_align_buffer_pkg.sv
// Shared constants for the store alignment buffer: size-mask encodings and
// the default lane width.
package store_align_buffer_pkg;

   localparam int DEFAULT_BYTE_WIDTH = 8;

   localparam logic [3:0] MASK_NONE = 4'b0000;
   localparam logic [3:0] MASK_BYTE = 4'b0001;
   localparam logic [3:0] MASK_HALF = 4'b0011;
   localparam logic [3:0] MASK_WORD = 4'b1111;

   // True for the four size encodings a store may legally carry.
   function automatic logic mask_is_legal(input logic [3:0] mask);
      return (mask == MASK_NONE) || (mask == MASK_BYTE) ||
             (mask == MASK_HALF) || (mask == MASK_WORD);
   endfunction

endpackage

// File: rtl/store_align_buffer_aligner.sv
// Combinational lane alignment of a right-justified store: shifts data and
// size mask to the byte offset and flags requests that cannot be written.
module store_aligner
   import store_align_buffer_pkg::*;
#(
   parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH
) (
   input  logic [1:0]              offset,
   input  logic [4*BYTE_WIDTH-1:0] data,
   input  logic [3:0]              mask,
   output logic [4*BYTE_WIDTH-1:0] aligned_data,
   output logic [3:0]              byte_en,
   output logic                    misaligned,
   output logic                    no_op
);

   logic [7:0] wide_mask;

   always_comb begin
      // Upper nibble of the widened mask catches lanes pushed past lane 3.
      wide_mask    = {4'b0000, mask} << offset;
      byte_en      = wide_mask[3:0];
      no_op        = (mask == MASK_NONE);
      misaligned   = !no_op && (!mask_is_legal(mask) || (wide_mask[7:4] != 4'b0000));
      aligned_data = data << (int'(offset) * BYTE_WIDTH);
   end

endmodule

// File: rtl/store_align_buffer.sv
// Store alignment buffer: aligns execute-stage stores to word lanes and
// queues them in a small circular FIFO ahead of the data-memory write port.
module store_align_buffer
   import store_align_buffer_pkg::*;
#(
   parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH,
   parameter int DEPTH      = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    st_valid,
   output logic                    st_ready,
   input  logic [31:0]             st_addr,
   input  logic [4*BYTE_WIDTH-1:0] st_data,
   input  logic [3:0]              st_mask,
   output logic                    mem_wr_valid,
   input  logic                    mem_wr_ready,
   output logic [31:0]             mem_wr_addr,
   output logic [4*BYTE_WIDTH-1:0] mem_wr_data,
   output logic [3:0]              mem_wr_be,
   output logic                    misaligned,
   output logic                    empty
);

   localparam int DW = 4 * BYTE_WIDTH;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // Producers hold valid and payload stable until that edge; ready never
   // depends combinationally on the partner's valid.

   logic [DW-1:0] al_data;
   logic [3:0]    al_be;
   logic          al_mis;
   logic          al_noop;

   store_aligner #(
      .BYTE_WIDTH(BYTE_WIDTH)
   ) u_aligner (
      .offset      (st_addr[1:0]),
      .data        (st_data),
      .mask        (st_mask),
      .aligned_data(al_data),
      .byte_en     (al_be),
      .misaligned  (al_mis),
      .no_op       (al_noop)
   );

   logic [31:0]   addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [3:0]    be_mem   [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic accept;
   logic enq;
   logic deq;

   assign st_ready     = (count < DEPTH_C);
   assign mem_wr_valid = (count != '0);
   assign empty        = (count == '0);

   // Rejected and no-op requests are consumed but never occupy an entry.
   assign accept = st_valid && st_ready;
   assign enq    = accept && !al_mis && !al_noop;
   assign deq    = mem_wr_valid && mem_wr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         misaligned <= 1'b0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         misaligned <= accept && al_mis;
      end
   end

   // Entry storage is not reset; head outputs are meaningful only while valid.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_mem[wr_ptr] <= {st_addr[31:2], 2'b00};
         data_mem[wr_ptr] <= al_data;
         be_mem[wr_ptr]   <= al_be;
      end
   end

   assign mem_wr_addr = addr_mem[rd_ptr];
   assign mem_wr_data = data_mem[rd_ptr];
   assign mem_wr_be   = be_mem[rd_ptr];

endmodule

// File: tb/tb_store_align_buffer.sv
// Randomized and directed bench for store_align_buffer against a queue-based
// reference model of the expected memory writes.
module tb_store_align_buffer;

   localparam int BW    = 8;
   localparam int DEPTH = 2;
   localparam int DW    = 4 * BW;

   logic          clk;
   logic          rst;
   logic          st_valid;
   logic          st_ready;
   logic [31:0]   st_addr;
   logic [DW-1:0] st_data;
   logic [3:0]    st_mask;
   logic          mem_wr_valid;
   logic          mem_wr_ready;
   logic [31:0]   mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic [3:0]    mem_wr_be;
   logic          misaligned;
   logic          empty;

   store_align_buffer #(
      .BYTE_WIDTH(BW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .st_valid    (st_valid),
      .st_ready    (st_ready),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .st_mask     (st_mask),
      .mem_wr_valid(mem_wr_valid),
      .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_be   (mem_wr_be),
      .misaligned  (misaligned),
      .empty       (empty)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [67:0] exp_q[$];   // {addr, data, be} of writes still owed
   bit exp_mis = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference rules: widths 1/2/4 bytes, must fit inside the word.
   task automatic model_align(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                              output bit mis, output bit noop, output logic [67:0] entry);
      int off;
      int width;
      logic [31:0] ea;
      logic [31:0] ed;
      logic [3:0]  ebe;
      off = int'(a % 4);
      case (m)
         4'b0001: width = 1;
         4'b0011: width = 2;
         4'b1111: width = 4;
         default: width = -1;
      endcase
      noop = (m == 4'b0000);
      mis  = !noop && (width < 0 || off + width > 4);
      ea   = a - 32'(off);
      ed   = d << (8 * off);
      ebe  = 4'(int'(m) << off);
      entry = {ea, ed, ebe};
   endtask

   task automatic check_outputs();
      logic [67:0] h;
      check_val("st_ready", 32'(st_ready), 32'(exp_q.size() < DEPTH));
      check_val("mem_wr_valid", 32'(mem_wr_valid), 32'(exp_q.size() != 0));
      check_val("empty", 32'(empty), 32'(exp_q.size() == 0));
      check_val("misaligned", 32'(misaligned), 32'(exp_mis));
      if (exp_q.size() != 0) begin
         h = exp_q[0];
         check_val("wr_addr", mem_wr_addr, h[67:36]);
         check_val("wr_data", mem_wr_data, h[35:4]);
         check_val("wr_be", 32'(mem_wr_be), 32'(h[3:0]));
      end
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge: drive, check registered outputs, advance model, clock.
   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic rdy, input logic r);
      bit ready_m;
      bit valid_m;
      bit mis;
      bit noop;
      logic [67:0] entry;
      st_valid = v; st_addr = a; st_data = d; st_mask = m;
      mem_wr_ready = rdy; rst = r;
      check_outputs();
      if (r) begin
         exp_q.delete();
         exp_mis = 1'b0;
      end else begin
         ready_m = exp_q.size() < DEPTH;
         valid_m = exp_q.size() != 0;
         model_align(a, d, m, mis, noop, entry);
         if (valid_m && rdy) void'(exp_q.pop_front());
         if (v && ready_m && !mis && !noop) exp_q.push_back(entry);
         exp_mis = v && ready_m && mis;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 32'h0, 4'b0000, rdy, 1'b0);
   endtask

   task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      check_val({tag, "_valid"}, 32'(mem_wr_valid), 32'd1);
      check_val({tag, "_addr"}, mem_wr_addr, a);
      check_val({tag, "_data"}, mem_wr_data, d);
      check_val({tag, "_be"}, 32'(mem_wr_be), 32'(be));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0]  m;
      logic [31:0] d;
      int k;
      rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0; mem_wr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Byte store into lane 3.
      step(1'b1, 32'h0000_1003, 32'h0000_00AB, 4'b0001, 1'b0, 1'b0);
      check_head("byte3", 32'h0000_1000, 32'hAB00_0000, 4'b1000);
      idle(1'b1);

      // Half store into upper half, then an unaligned half.
      step(1'b1, 32'h0000_2002, 32'h0000_BEEF, 4'b0011, 1'b0, 1'b0);
      check_head("half2", 32'h0000_2000, 32'hBEEF_0000, 4'b1100);
      idle(1'b1);
      step(1'b1, 32'h0000_2003, 32'h0000_BEEF, 4'b0011, 1'b1, 1'b0);
      check_val("half3_mis", 32'(misaligned), 32'd1);
      check_val("half3_nowrite", 32'(mem_wr_valid), 32'd0);
      idle(1'b1);

      // No-op mask: consumed silently.
      step(1'b1, 32'h0000_3001, 32'h0000_0055, 4'b0000, 1'b1, 1'b0);
      check_val("noop_mis", 32'(misaligned), 32'd0);
      check_val("noop_nowrite", 32'(mem_wr_valid), 32'd0);

      // Back-pressure: third word stalls until the memory drains.
      step(1'b1, 32'h0000_4000, 32'h1111_1111, 4'b1111, 1'b0, 1'b0);
      step(1'b1, 32'h0000_4004, 32'h2222_2222, 4'b1111, 1'b0, 1'b0);
      check_val("full_ready", 32'(st_ready), 32'd0);
      step(1'b1, 32'h0000_4008, 32'h3333_3333, 4'b1111, 1'b0, 1'b0);
      step(1'b1, 32'h0000_4008, 32'h3333_3333, 4'b1111, 1'b0, 1'b0);
      check_head("order0", 32'h0000_4000, 32'h1111_1111, 4'b1111);
      for (int i = 0; i < 8; i++)
         step(1'b1, 32'h0000_4008 + 32'(4 * i), 32'h3333_3333 + 32'(i), 4'b1111, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Reset with two entries pending.
      step(1'b1, 32'h0000_5000, 32'hAAAA_AAAA, 4'b1111, 1'b0, 1'b0);
      step(1'b1, 32'h0000_5004, 32'hBBBB_BBBB, 4'b1111, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1);
      check_val("rst_valid", 32'(mem_wr_valid), 32'd0);
      check_val("rst_empty", 32'(empty), 32'd1);
      idle(1'b1);
      idle(1'b1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         k = int'($urandom_range(0, 9));
         if (k <= 2)      m = 4'b0001;
         else if (k <= 5) m = 4'b0011;
         else if (k <= 7) m = 4'b1111;
         else if (k == 8) m = 4'b0000;
         else             m = 4'($urandom_range(0, 15));
         d = $urandom;
         if (m == 4'b0001) d = d & 32'h0000_00FF;
         if (m == 4'b0011) d = d & 32'h0000_FFFF;
         step(1'($urandom_range(0, 1)), $urandom, d, m,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
